fp_add2_stream_ctrl: RTL and testbench

FP_ADD2_STREAM_CTRL -- requirements
Module: fp_add2_stream_ctrl

---
 rtl/fp_add2_stream_ctrl_pkg.sv | 43 ++++
 rtl/fp_add2_stream_ctrl_if.sv | 26 ++
 rtl/fp_add2_res_fifo.sv | 50 +++++
 rtl/fp_add2_stream_ctrl.sv | 85 ++++++++
 tb/tb_fp_add2_stream_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/fp_add2_stream_ctrl_pkg.sv
// Shared definitions for the binary32 add stream controller.
// Holds the field widths, the result-class bit positions, the rounding-mode
// encodings, the FIFO entry layout and the classification helper.
package fp_add2_stream_ctrl_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int FP_W  = 32;
  localparam int RM_W  = 3;
  localparam int CLS_W = 3;

  // Positions inside the {nan, inf, zero} class vector
  localparam int CLS_NAN  = 2;
  localparam int CLS_INF  = 1;
  localparam int CLS_ZERO = 0;

  typedef enum logic [RM_W-1:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RUP = 3'd2,
    RM_RDN = 3'd3,
    RM_RMM = 3'd4
  } rm_e;

  // One result FIFO entry: packed value plus its class
  typedef struct packed {
    logic [FP_W-1:0]  x;
    logic [CLS_W-1:0] cls;
  } res_t;

  localparam int RES_W = FP_W + CLS_W;

  // Subnormals and normals both classify as 000
  function automatic logic [CLS_W-1:0] fp_cls(input logic [FP_W-1:0] v);
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    e = v[FP_W-2 -: EXP_W];
    m = v[MAN_W-1:0];
    fp_cls           = '0;
    fp_cls[CLS_NAN]  = (&e) & (|m);
    fp_cls[CLS_INF]  = (&e) & ~(|m);
    fp_cls[CLS_ZERO] = ~(|e) & ~(|m);
  endfunction
endpackage

// File: rtl/fp_add2_stream_ctrl_if.sv
// Operand and result stream channels of the add controller.
// master: the producer of operands / consumer of results.
// slave : the controller itself.
interface fp_add2_stream_ctrl_if;
  import fp_add2_stream_ctrl_pkg::*;

  logic             op_valid;
  logic             op_ready;
  logic [FP_W-1:0]  op_a;
  logic [FP_W-1:0]  op_b;
  logic [RM_W-1:0]  op_rm;
  logic             res_valid;
  logic             res_ready;
  logic [FP_W-1:0]  res_x;
  logic [CLS_W-1:0] res_cls;

  modport master (
    output op_valid, op_a, op_b, op_rm, res_ready,
    input  op_ready, res_valid, res_x, res_cls
  );

  modport slave (
    input  op_valid, op_a, op_b, op_rm, res_ready,
    output op_ready, res_valid, res_x, res_cls
  );
endinterface

// File: rtl/fp_add2_res_fifo.sv
// Two-entry result FIFO (value + class, 35 bits).
// Ports: aclk/arst_n; push/din write; pop/dout read from head;
// full/empty/count status. Push while full is only taken together with a pop.
module fp_add2_res_fifo
  import fp_add2_stream_ctrl_pkg::*;
(
  input  logic       aclk,
  input  logic       arst_n,
  input  logic       push,
  input  res_t       din,
  input  logic       pop,
  output res_t       dout,
  output logic       full,
  output logic       empty,
  output logic [1:0] count
);
  res_t       mem [2];
  logic       wr_ptr, rd_ptr;
  logic [1:0] cnt;
  logic       do_push, do_pop;

  assign do_pop  = pop & (cnt != 2'd0);
  assign do_push = push & ((cnt != 2'd2) | do_pop);

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: count gates every read
  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (cnt == 2'd2);
  assign empty = (cnt == 2'd0);
  assign count = cnt;
endmodule

// File: rtl/fp_add2_stream_ctrl.sv
// Stream controller around an external binary32 adder core.
// Ports: aclk/arst_n; strm (operand + result handshakes); unpacked operands
// a_*/b_* and rm to the core; astall holds the core output register;
// x is the core's registered result; busy flags any work in flight.
// Pipeline: S0 (operands, v0) -> core register (v1) -> 2-entry result FIFO.
module fp_add2_stream_ctrl
  import fp_add2_stream_ctrl_pkg::*;
(
  input  logic                 aclk,
  input  logic                 arst_n,
  fp_add2_stream_ctrl_if.slave strm,
  output logic                 a_sign,
  output logic [EXP_W-1:0]     a_exp,
  output logic [MAN_W-1:0]     a_man,
  output logic                 b_sign,
  output logic [EXP_W-1:0]     b_exp,
  output logic [MAN_W-1:0]     b_man,
  output logic [RM_W-1:0]      rm,
  output logic                 astall,
  input  logic [FP_W-1:0]      x,
  output logic                 busy
);
  localparam int STAGES = 1;

  // vld_pipe[0] = v0 (S0 holds an op), vld_pipe[1] = v1 (x is valid)
  logic [STAGES:0]  vld_pipe;
  logic [FP_W-1:0]  s0_a, s0_b;
  logic [RM_W-1:0]  s0_rm;
  logic             advance, push, pop;
  logic             fifo_full, fifo_empty;
  logic [1:0]       fifo_count;
  res_t             push_data, head;

  // Stall only when a valid core result has nowhere to go. Uses the
  // pre-edge full flag: a pop on the same edge frees space for the next one.
  assign advance = ~(vld_pipe[STAGES] & fifo_full);
  assign astall  = ~advance;

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      vld_pipe <= '0;
      s0_a     <= '0;
      s0_b     <= '0;
      s0_rm    <= '0;
    end else if (advance) begin
      vld_pipe <= {vld_pipe[STAGES-1:0], strm.op_valid};
      if (strm.op_valid) begin
        s0_a  <= strm.op_a;
        s0_b  <= strm.op_b;
        s0_rm <= strm.op_rm;
      end
    end
  end

  assign a_sign = s0_a[FP_W-1];
  assign a_exp  = s0_a[FP_W-2 -: EXP_W];
  assign a_man  = s0_a[MAN_W-1:0];
  assign b_sign = s0_b[FP_W-1];
  assign b_exp  = s0_b[FP_W-2 -: EXP_W];
  assign b_man  = s0_b[MAN_W-1:0];
  assign rm     = s0_rm;

  // x is only trusted while v1 is set (core register has no reset)
  assign push      = vld_pipe[STAGES] & ~fifo_full;
  assign pop       = ~fifo_empty & strm.res_ready;
  assign push_data = {x, fp_cls(x)};

  fp_add2_res_fifo u_fifo (
    .aclk   (aclk),
    .arst_n (arst_n),
    .push   (push),
    .din    (push_data),
    .pop    (pop),
    .dout   (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign strm.op_ready  = advance;
  assign strm.res_valid = ~fifo_empty;
  assign strm.res_x     = head.x;
  assign strm.res_cls   = head.cls;
  assign busy           = (|vld_pipe) | (fifo_count != 2'd0);
endmodule

// File: tb/tb_fp_add2_stream_ctrl.sv
// Directed bench for fp_add2_stream_ctrl with a stand-in adder core register.
module tb_fp_add2_stream_ctrl;
  import fp_add2_stream_ctrl_pkg::*;

  logic             aclk = 1'b0;
  logic             arst_n = 1'b0;
  logic             a_sign, b_sign, astall, busy;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_man, b_man;
  logic [RM_W-1:0]  rm;
  logic [FP_W-1:0]  x;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] CLS_VAL [4] = '{32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h00000001};
  localparam logic [2:0]  CLS_EXP [4] = '{3'b100, 3'b010, 3'b001, 3'b000};

  fp_add2_stream_ctrl_if bus();

  fp_add2_stream_ctrl dut (
    .aclk   (aclk),
    .arst_n (arst_n),
    .strm   (bus.slave),
    .a_sign (a_sign),
    .a_exp  (a_exp),
    .a_man  (a_man),
    .b_sign (b_sign),
    .b_exp  (b_exp),
    .b_man  (b_man),
    .rm     (rm),
    .astall (astall),
    .x      (x),
    .busy   (busy)
  );

  always #5 aclk = ~aclk;

  // Stand-in core: 1.0 + 2.0 gives 3.0, anything else gives a ^ b so that
  // vectors with b = 0 pass a straight through and b = 0x40000000 tags them.
  function automatic logic [31:0] core_f(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    return a ^ b;
  endfunction

  always @(posedge aclk)
    if (!astall) x <= core_f({a_sign, a_exp, a_man}, {b_sign, b_exp, b_man});

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.op_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.op_rm     = '0;
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset;
    arst_n = 1'b0;
    idle_inputs();
    repeat (3) tick();
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b want 0", bus.res_valid); end
    checks++; if (bus.op_ready !== 1'b1) begin errors++; $display("FAIL reset_op_ready got %b want 1", bus.op_ready); end
    checks++; if (astall !== 1'b0) begin errors++; $display("FAIL reset_astall got %b want 0", astall); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if ({a_sign, a_exp, a_man, b_sign, b_exp, b_man, rm} !== 67'd0) begin
      errors++; $display("FAIL reset_core_ports got %h want 0", {a_sign, a_exp, a_man, b_sign, b_exp, b_man, rm}); end
    arst_n = 1'b1;
    tick();
  endtask

  // 1.0 + 2.0 with result valid after the third edge
  task automatic single_op(input string tag);
    bus.res_ready = 1'b1;
    bus.op_valid = 1'b1; bus.op_a = 32'h3F800000; bus.op_b = 32'h40000000; bus.op_rm = 3'd4;
    tick();
    bus.op_valid = 1'b0;
    checks++; if ({a_sign, a_exp, a_man} !== {1'b0, 8'h7F, 23'd0}) begin errors++; $display("FAIL %s_a_fields got %h want 0 7f 0", tag, {a_sign, a_exp, a_man}); end
    checks++; if ({b_sign, b_exp, b_man} !== {1'b0, 8'h80, 23'd0}) begin errors++; $display("FAIL %s_b_fields got %h want 0 80 0", tag, {b_sign, b_exp, b_man}); end
    checks++; if (rm !== 3'd4) begin errors++; $display("FAIL %s_rm got %0d want 4", tag, rm); end
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL %s_early_valid_e0 got %b want 0", tag, bus.res_valid); end
    tick();
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL %s_early_valid_e1 got %b want 0", tag, bus.res_valid); end
    tick();
    checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL %s_valid_e2 got %b want 1", tag, bus.res_valid); end
    checks++; if (bus.res_x !== 32'h40400000) begin errors++; $display("FAIL %s_res_x got %h want 40400000", tag, bus.res_x); end
    checks++; if (bus.res_cls !== 3'b000) begin errors++; $display("FAIL %s_res_cls got %b want 000", tag, bus.res_cls); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy_e2 got %b want 1", tag, busy); end
    tick();
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL %s_valid_e3 got %b want 0", tag, bus.res_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_e3 got %b want 0", tag, busy); end
  endtask

  task automatic test_single;
    single_op("single");
  endtask

  // 8 back-to-back ops, op i: a = 0x100+i, b = 0x40000000 -> x = 0x40000100+i
  task automatic test_back_to_back;
    int rcv = 0, first = -1, last = -1;
    logic stall_seen = 1'b0;
    bus.res_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c < 8) begin
        bus.op_valid = 1'b1; bus.op_a = 32'h00000100 + c; bus.op_b = 32'h40000000; bus.op_rm = 3'd0;
      end else bus.op_valid = 1'b0;
      stall_seen |= astall;
      if (bus.res_valid && bus.res_ready) begin
        checks++; if (bus.res_x !== 32'h40000100 + rcv) begin errors++; $display("FAIL stream_data[%0d] got %h want %h", rcv, bus.res_x, 32'h40000100 + rcv); end
        if (first < 0) first = c;
        last = c;
        rcv++;
      end
      tick();
    end
    checks++; if (rcv !== 8) begin errors++; $display("FAIL stream_count got %0d want 8", rcv); end
    checks++; if (last - first !== 7) begin errors++; $display("FAIL stream_consecutive got span %0d want 7", last - first); end
    checks++; if (stall_seen !== 1'b0) begin errors++; $display("FAIL stream_astall got %b want 0", stall_seen); end
  endtask

  // 6 ops into a blocked output, released after 8 cycles
  task automatic test_backpressure;
    int sent = 0, rcv = 0;
    logic acc, popd;
    for (int c = 0; c < 40; c++) begin
      bus.res_ready = (c >= 8);
      if (sent < 6) begin
        bus.op_valid = 1'b1; bus.op_a = 32'h00000200 + sent; bus.op_b = 32'h40000000;
      end else bus.op_valid = 1'b0;
      acc  = bus.op_valid && bus.op_ready;
      popd = bus.res_valid && bus.res_ready;
      if (popd) begin
        checks++; if (bus.res_x !== 32'h40000200 + rcv) begin errors++; $display("FAIL bp_order[%0d] got %h want %h", rcv, bus.res_x, 32'h40000200 + rcv); end
      end
      if (c == 6) begin
        checks++; if (astall !== 1'b1) begin errors++; $display("FAIL bp_astall got %b want 1", astall); end
        checks++; if (bus.op_ready !== 1'b0) begin errors++; $display("FAIL bp_op_ready got %b want 0", bus.op_ready); end
        checks++; if (sent !== 4) begin errors++; $display("FAIL bp_accepted got %0d want 4", sent); end
        checks++; if (bus.res_x !== 32'h40000200) begin errors++; $display("FAIL bp_head got %h want 40000200", bus.res_x); end
      end
      tick();
      if (acc) sent++;
      if (popd) rcv++;
    end
    checks++; if (rcv !== 6) begin errors++; $display("FAIL bp_count got %0d want 6", rcv); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy_end got %b want 0", busy); end
  endtask

  // Fill to the stalled state: FIFO = {op0, op1}, v1 = op2, v0 = op3
  task automatic fill_stalled(input logic [31:0] base);
    bus.res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.op_valid = 1'b1; bus.op_a = base + i; bus.op_b = 32'h40000000;
      tick();
    end
    bus.op_valid = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_full_push_pop;
    fill_stalled(32'h00000300);
    checks++; if (astall !== 1'b1) begin errors++; $display("FAIL fpp_stall_pre got %b want 1", astall); end
    checks++; if (bus.res_x !== 32'h40000300) begin errors++; $display("FAIL fpp_head0 got %h want 40000300", bus.res_x); end
    bus.res_ready = 1'b1;
    tick();
    checks++; if (astall !== 1'b0) begin errors++; $display("FAIL fpp_stall_1 got %b want 0", astall); end
    checks++; if (bus.res_x !== 32'h40000301) begin errors++; $display("FAIL fpp_head1 got %h want 40000301", bus.res_x); end
    tick();
    checks++; if (bus.res_valid !== 1'b1 || bus.res_x !== 32'h40000302) begin errors++; $display("FAIL fpp_head2 got %b/%h want 1/40000302", bus.res_valid, bus.res_x); end
    checks++; if (astall !== 1'b0) begin errors++; $display("FAIL fpp_stall_2 got %b want 0", astall); end
    tick();
    checks++; if (bus.res_valid !== 1'b1 || bus.res_x !== 32'h40000303) begin errors++; $display("FAIL fpp_head3 got %b/%h want 1/40000303", bus.res_valid, bus.res_x); end
    tick();
    checks++; if (bus.res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL fpp_drained got valid %b busy %b want 0 0", bus.res_valid, busy); end
  endtask

  task automatic test_classify;
    int rcv = 0;
    bus.res_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c < 4) begin
        bus.op_valid = 1'b1; bus.op_a = CLS_VAL[c]; bus.op_b = 32'h0;
      end else bus.op_valid = 1'b0;
      if (bus.res_valid && rcv < 4) begin
        checks++; if (bus.res_x !== CLS_VAL[rcv]) begin errors++; $display("FAIL cls_x[%0d] got %h want %h", rcv, bus.res_x, CLS_VAL[rcv]); end
        checks++; if (bus.res_cls !== CLS_EXP[rcv]) begin errors++; $display("FAIL cls_bits[%0d] got %b want %b", rcv, bus.res_cls, CLS_EXP[rcv]); end
        rcv++;
      end
      tick();
    end
    checks++; if (rcv !== 4) begin errors++; $display("FAIL cls_count got %0d want 4", rcv); end
  endtask

  task automatic test_reset_midop;
    fill_stalled(32'h00000400);
    checks++; if (astall !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL rst_mid_pre got astall %b busy %b want 1 1", astall, busy); end
    #2;
    arst_n = 1'b0;
    #1;
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b want 0", bus.res_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    checks++; if (astall !== 1'b0 || bus.op_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_stall got astall %b op_ready %b want 0 1", astall, bus.op_ready); end
    idle_inputs();
    repeat (2) tick();
    arst_n = 1'b1;
    tick();
    single_op("post_rst");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_full_push_pop();
    test_classify();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
